// File: rtl/cyclogram_pkg.sv
// Shared definitions for the cyclogram sequencer and its program-RAM bank controller:
// command codes, controller FSM encoding and default geometry.
package cyclogram_pkg;

   // Default geometry
   localparam int AW_DEF        = 8;    // sequencer address width, 2^AW words per bank
   localparam int DW_DEF        = 16;   // program RAM data width
   localparam int PW_DEF        = 16;   // restart period counter width
   localparam int START_LEN_DEF = 3;    // start pulse length; the sequencer needs at least 2 highs

   // Pulse command codes
   localparam logic [7:0] CMD_TNO  = 8'h01;
   localparam logic [7:0] CMD_TNC  = 8'h02;
   localparam logic [7:0] CMD_TNI  = 8'h03;
   localparam logic [7:0] CMD_TNP  = 8'h04;
   localparam logic [7:0] CMD_TKI  = 8'h05;
   localparam logic [7:0] CMD_TKP  = 8'h06;
   localparam logic [7:0] CMD_TOBM = 8'h07;

   // Interval command codes
   localparam logic [7:0] CMD_DNIU = 8'h10;
   localparam logic [7:0] CMD_DNIP = 8'h11;
   localparam logic [7:0] CMD_DTNO = 8'h12;
   localparam logic [7:0] CMD_DTNC = 8'h13;

   // End of program marker
   localparam logic [7:0] CMD_END  = 8'hFF;

   // Restart scheduler states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

endpackage

// File: rtl/cyclogram_bank_ctrl_if.sv
// Host write bus and program-RAM port of the bank controller.
// master = host/RAM side, slave = controller side.
interface cyclogram_bank_ctrl_if
   import cyclogram_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   // host write side
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          commit;
   logic          wr_rej;
   logic          commit_done;
   logic          pending;
   // RAM side
   logic          ram_we;
   logic [AW:0]   ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic [AW-1:0] addr_rd;
   logic [AW:0]   ram_raddr;

   modport master (
      output wr_en, wr_addr, wr_data, commit, addr_rd,
      input  wr_rej, commit_done, pending, ram_we, ram_waddr, ram_wdata, ram_raddr
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, commit, addr_rd,
      output wr_rej, commit_done, pending, ram_we, ram_waddr, ram_wdata, ram_raddr
   );

endinterface

// File: rtl/tus_tick_sync.sv
// Synchronises the asynchronous 1 us Tus strobe and produces a single-clock
// tick two clocks after its rising edge. Shared with the sequencer.
module tus_tick_sync (
   input  logic clk,
   input  logic rst,
   input  logic tus_in,
   output logic tick
);

   logic [2:0] shift_q;
   logic [2:0] shift_d;

   // shift the strobe in, newest sample in bit 0
   always_comb begin
      shift_d = {shift_q[1:0], tus_in};
   end

   // synchroniser flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= 3'b000;
      end else begin
         shift_q <= shift_d;
      end
   end

   // rising edge seen in the two newest samples, older sample still low
   assign tick = (shift_q == 3'b011);

endmodule

// File: rtl/cyclogram_bank_ctrl.sv
// Double-buffered program-RAM controller and restart scheduler.
// The host fills the inactive bank; a commit marks it ready and the banks swap
// only at a sequence-start boundary (or at once while idle). Start pulses are
// issued on a programmable period of Tus ticks or on a manual trigger.
module cyclogram_bank_ctrl
   import cyclogram_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int PW        = PW_DEF,
   parameter int START_LEN = START_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Tus,
   input  logic                 run,
   input  logic                 trig,
   input  logic [PW-1:0]        period_us,
   cyclogram_bank_ctrl_if.slave bus,
   output logic                 active_bank,
   output logic                 start,
   output logic [15:0]          seq_cnt
);

   localparam int            PCW     = $clog2(START_LEN);
   localparam logic [PCW-1:0] P_LAST = PCW'(START_LEN - 1);
   localparam logic [PW-1:0]  CNT_MAX = {PW{1'b1}};

   state_e         state_q, state_d;
   logic           start_q, start_d;
   logic [PCW-1:0] pcnt_q, pcnt_d;
   logic [PW-1:0]  per_q, per_d;
   logic [PW-1:0]  cnt_q, cnt_d;
   logic [15:0]    seq_q, seq_d;
   logic           active_q, active_d;
   logic           pending_q, pending_d;
   logic           commit_done_q, commit_done_d;
   logic           wr_rej_q, wr_rej_d;
   logic           ram_we_q, ram_we_d;
   logic [AW:0]    ram_waddr_q, ram_waddr_d;
   logic [DW-1:0]  ram_wdata_q, ram_wdata_d;

   logic           tick_s;
   logic           enter_s;
   logic           swap_s;

   tus_tick_sync u_tus_sync (
      .clk    (clk),
      .rst    (rst),
      .tus_in (Tus),
      .tick   (tick_s)
   );

   // next-state logic: scheduler, bank swap and host write path
   always_comb begin
      state_d       = state_q;
      start_d       = start_q;
      pcnt_d        = pcnt_q;
      per_d         = per_q;
      cnt_d         = cnt_q;
      seq_d         = seq_q;
      active_d      = active_q;
      pending_d     = pending_q;
      commit_done_d = 1'b0;
      wr_rej_d      = 1'b0;
      ram_we_d      = 1'b0;
      ram_waddr_d   = ram_waddr_q;
      ram_wdata_d   = ram_wdata_q;
      enter_s       = 1'b0;
      swap_s        = 1'b0;

      // tick counter saturates instead of wrapping so a long period never restarts early
      if (tick_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + PW'(1);
      end else begin
         cnt_d = cnt_q;
      end

      case (state_q)
         S_IDLE: begin
            if (trig || run) begin
               enter_s = 1'b1;
            end else if (pending_q || bus.commit) begin
               // nothing is running, so a ready bank can go live right away
               swap_s = 1'b1;
            end else begin
               swap_s = 1'b0;
            end
         end
         S_PULSE: begin
            // the pulse always runs to full length; trig and run are not looked at
            if (pcnt_q == P_LAST) begin
               state_d = S_WAIT;
               start_d = 1'b0;
            end else begin
               pcnt_d = pcnt_q + PCW'(1);
            end
         end
         S_WAIT: begin
            if (trig) begin
               enter_s = 1'b1;
            end else if (!run) begin
               state_d = S_IDLE;
            end else if ((per_q != {PW{1'b0}}) && (cnt_q >= per_q)) begin
               enter_s = 1'b1;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d = S_IDLE;
            start_d = 1'b0;
         end
      endcase

      // sequence-start boundary; only a commit registered before this clock swaps here
      if (enter_s) begin
         state_d = S_PULSE;
         start_d = 1'b1;
         pcnt_d  = {PCW{1'b0}};
         per_d   = period_us;
         cnt_d   = {PW{1'b0}};
         seq_d   = seq_q + 16'd1;
         swap_s  = pending_q;
      end else begin
         seq_d   = seq_q;
      end

      if (swap_s) begin
         active_d      = ~active_q;
         pending_d     = 1'b0;
         commit_done_d = 1'b1;
      end else if (bus.commit) begin
         pending_d     = 1'b1;
      end else begin
         pending_d     = pending_q;
      end

      // host writes always target the inactive bank and are frozen once committed
      if (bus.wr_en) begin
         if (pending_q) begin
            wr_rej_d = 1'b1;
         end else begin
            ram_we_d    = 1'b1;
            ram_waddr_d = {~active_q, bus.wr_addr};
            ram_wdata_d = bus.wr_data;
         end
      end else begin
         ram_we_d = 1'b0;
      end
   end

   // state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         start_q       <= 1'b0;
         pcnt_q        <= {PCW{1'b0}};
         per_q         <= {PW{1'b0}};
         cnt_q         <= {PW{1'b0}};
         seq_q         <= 16'd0;
         active_q      <= 1'b0;
         pending_q     <= 1'b0;
         commit_done_q <= 1'b0;
         wr_rej_q      <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_waddr_q   <= {(AW+1){1'b0}};
         ram_wdata_q   <= {DW{1'b0}};
      end else begin
         state_q       <= state_d;
         start_q       <= start_d;
         pcnt_q        <= pcnt_d;
         per_q         <= per_d;
         cnt_q         <= cnt_d;
         seq_q         <= seq_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         commit_done_q <= commit_done_d;
         wr_rej_q      <= wr_rej_d;
         ram_we_q      <= ram_we_d;
         ram_waddr_q   <= ram_waddr_d;
         ram_wdata_q   <= ram_wdata_d;
      end
   end

   assign start           = start_q;
   assign active_bank     = active_q;
   assign seq_cnt         = seq_q;
   assign bus.pending     = pending_q;
   assign bus.commit_done = commit_done_q;
   assign bus.wr_rej      = wr_rej_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_waddr   = ram_waddr_q;
   assign bus.ram_wdata   = ram_wdata_q;
   // read address follows the live bank with no register delay
   assign bus.ram_raddr   = {active_q, bus.addr_rd};

endmodule
